// File: rtl/pll_lock_pkg.sv
// Shared types and helpers for the PLL bring-up/supervision block.
package pll_lock_pkg;

  // Supervisor states, in bring-up order; FAIL is absorbing.
  typedef enum logic [2:0] {
    RESET_PLL    = 3'd0,
    WAIT_LOCK    = 3'd1,
    STABLE_CHECK = 3'd2,
    RUN          = 3'd3,
    FAIL         = 3'd4
  } state_t;

  // Width of the shared cycle counter: enough to reach the largest
  // terminal count among the three per-state durations.
  function automatic int cnt_width(input int rst_cycles, input int stable_cycles,
                                   input int timeout_cycles);
    int m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// Cleared asynchronously so the synchronized value reads 0 during reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Shift the raw input through the flop chain; oldest sample is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL bring-up sequencer and lock supervisor, clocked by the free-running
// reference clock. Pulses the PLL reset, waits for a stable lock, releases
// the system reset, and restarts on lock loss. Repeated lock timeouts end in
// a sticky FAIL state that only cpu_reset_n can leave.
module pll_lock_monitor
  import pll_lock_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 65536,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                               clk100,
  input  logic                               cpu_reset_n,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic                               sys_reset,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic                               fail
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [RW-1:0]   retry_reg, retry_next;
  logic            pll_rst_reg, pll_rst_next;
  logic            sys_reset_reg, sys_reset_next;
  logic            lock_lost_reg, lock_lost_next;
  logic            fail_reg, fail_next;
  logic            lk;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk100),
    .rst_n (cpu_reset_n),
    .d     (pll_locked),
    .q     (lk)
  );

  // Next-state, counter and retry logic; outputs are decoded from the next
  // state so every output flop changes on the same edge as the state.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    retry_next     = retry_reg;
    lock_lost_next = 1'b0;

    case (state_reg)
      RESET_PLL: begin
        if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle still counts as a lock.
        if (lk) begin
          state_next = STABLE_CHECK;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          if (retry_reg == RETRY_MAX) begin
            state_next = FAIL;
          end else begin
            retry_next = retry_reg + 1'b1;
            state_next = RESET_PLL;
          end
        end
      end
      STABLE_CHECK: begin
        // A drop on the final cycle still restarts the wait.
        if (!lk) begin
          state_next = WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          retry_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Counter has no terminal count here, so hold it rather than wrap.
        cnt_next = cnt_reg;
        if (!lk) begin
          lock_lost_next = 1'b1;
          state_next     = RESET_PLL;
        end
      end
      FAIL: begin
        cnt_next = cnt_reg;
      end
      default: begin
        state_next = RESET_PLL;
      end
    endcase

    if (state_next != state_reg) cnt_next = '0;

    pll_rst_next   = (state_next == RESET_PLL) || (state_next == FAIL);
    sys_reset_next = (state_next != RUN);
    fail_next      = (state_next == FAIL);
  end

  // State, shared counter and retry counter registers.
  always_ff @(posedge clk100 or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_reg <= RESET_PLL;
      cnt_reg   <= '0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
    end
  end

  // Registered outputs so nothing downstream sees decode glitches.
  always_ff @(posedge clk100 or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      pll_rst_reg   <= 1'b1;
      sys_reset_reg <= 1'b1;
      lock_lost_reg <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      pll_rst_reg   <= pll_rst_next;
      sys_reset_reg <= sys_reset_next;
      lock_lost_reg <= lock_lost_next;
      fail_reg      <= fail_next;
    end
  end

  assign pll_rst     = pll_rst_reg;
  assign sys_reset   = sys_reset_reg;
  assign lock_lost   = lock_lost_reg;
  assign retry_count = retry_reg;
  assign fail        = fail_reg;

endmodule
